// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package imem_pkg;

    localparam int unsigned IMEM_DATA_W = 32;
    localparam int unsigned IMEM_ADDR_W = 11;
    localparam int unsigned OPCODE_W    = 4;
    localparam logic [OPCODE_W-1:0] OP_END = 4'hF;
    localparam int unsigned IMEM_WORDS  = 1 << IMEM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Host, imem read-port and decoder-stream signals of the fetch controller.
// Optional IMEM_FETCH_PERF_EN adds the stall_cycles counter output.
interface imem_fetch_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 11
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   inst_count;
    logic                  abort;
    logic                  imem_read_req;
    logic [ADDR_WIDTH-1:0] imem_read_addr;
    logic [DATA_WIDTH-1:0] imem_read_data;
    logic                  inst_valid;
    logic [DATA_WIDTH-1:0] inst_data;
    logic                  inst_ready;
    logic                  busy;
    logic                  done;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0]           stall_cycles;
`endif

    // Environment side: host, memory and decoder
    modport master (
        output start, base_addr, inst_count, abort, imem_read_data, inst_ready,
        input  imem_read_req, imem_read_addr, inst_valid, inst_data, busy, done
`ifdef IMEM_FETCH_PERF_EN
        , input stall_cycles
`endif
    );

    // Fetch controller side
    modport slave (
        input  start, base_addr, inst_count, abort, imem_read_data, inst_ready,
        output imem_read_req, imem_read_addr, inst_valid, inst_data, busy, done
`ifdef IMEM_FETCH_PERF_EN
        , output stall_cycles
`endif
    );
endinterface

// File: rtl/imem_fetch_ctrl_skid_fifo.sv
// Two-entry FIFO holding fetched words until the decoder accepts them.
module fetch_skid_fifo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       occupancy_o
);

    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop_ok, push_ok;

    // Entry shuffling; e0 is always the head
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        pop_ok  = pop_i && (cnt_q != 2'd0);
        push_ok = push_i && ((cnt_q != 2'd2) || pop_ok);
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = push_data_i;
                    else               e1_d = push_data_i;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_d = push_data_i;
                    end else begin
                        e0_d = e1_q;
                        e1_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_o     = (cnt_q != 2'd0);
    assign head_o      = e0_q;
    assign occupancy_o = cnt_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: reads imem words from a base address and
// streams them to the decoder until the count runs out or an END opcode.
// Optional IMEM_FETCH_PERF_EN adds the stall_cycles backpressure counter.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IMEM_DATA_W,
    parameter int unsigned ADDR_WIDTH = IMEM_ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    imem_fetch_ctrl_if.slave ctl_if
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      remain_q, remain_d;
    logic                  inflight_q, inflight_d;
    logic                  busy_q, done_q;

    logic                  issue_c, push_c, pop_c, end_hit_c, flush_c, empty_next_c;
    logic [2:0]            load_c;
    logic [1:0]            occ;
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_head;

    // Next-state, issue and buffer control
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        inflight_d   = 1'b0;
        issue_c      = 1'b0;
        push_c       = 1'b0;
        end_hit_c    = 1'b0;
        flush_c      = 1'b0;
        pop_c        = fifo_valid && ctl_if.inst_ready;
        // A pop this cycle frees a slot before the newly issued read returns
        load_c       = 3'(occ) + 3'(inflight_q) - 3'(pop_c);
        empty_next_c = (occ == 2'd0) || ((occ == 2'd1) && pop_c);

        if (ctl_if.abort) begin
            state_d = IDLE;
            flush_c = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctl_if.start) begin
                        addr_d   = ctl_if.base_addr;
                        remain_d = ctl_if.inst_count;
                        state_d  = (ctl_if.inst_count == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    push_c    = inflight_q;
                    end_hit_c = inflight_q &&
                        (ctl_if.imem_read_data[DATA_WIDTH-1 -: OPCODE_W] == OP_END);
                    issue_c   = (remain_q != '0) && (load_c < 3'd2);
                    if (issue_c) begin
                        addr_d     = addr_q + ADDR_WIDTH'(1);
                        remain_d   = remain_q - CNT_W'(1);
                        inflight_d = 1'b1;
                    end
                    if (end_hit_c) begin
                        state_d = DRAIN;
                    end else if ((remain_q == '0) && !inflight_q) begin
                        state_d = empty_next_c ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    // A read issued alongside the END word lands here and is dropped
                    if (empty_next_c) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= inflight_d;
            busy_q     <= (state_d == FETCH) || (state_d == DRAIN);
            done_q     <= (state_d == DONE);
        end
    end

    fetch_skid_fifo #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush_c),
        .push_i      (push_c),
        .push_data_i (ctl_if.imem_read_data),
        .pop_i       (pop_c),
        .valid_o     (fifo_valid),
        .head_o      (fifo_head),
        .occupancy_o (occ)
    );

    assign ctl_if.imem_read_req  = issue_c;
    assign ctl_if.imem_read_addr = addr_q;
    assign ctl_if.inst_valid     = fifo_valid;
    assign ctl_if.inst_data      = fifo_head;
    assign ctl_if.busy           = busy_q;
    assign ctl_if.done           = done_q;

`ifdef IMEM_FETCH_PERF_EN
    logic        start_acc_c;
    logic [31:0] stall_q;

    assign start_acc_c = (state_q == IDLE) && ctl_if.start && !ctl_if.abort;

    // Saturating count of decoder-stalled cycles within a run
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (start_acc_c) begin
            stall_q <= '0;
        end else if (busy_q && fifo_valid && !ctl_if.inst_ready &&
                     (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign ctl_if.stall_cycles = stall_q;
`endif

endmodule
